// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for the sequential FP32 divider.
// master drives operands and out_ready; slave is the divider.
interface fp_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        div_zero;

  modport master (
    output in_valid, fp_X, fp_Y, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf, div_zero
  );

  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf, div_zero
  );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential FP32 divider, fp_Z = fp_X / fp_Y, restoring mantissa iteration.
// FP_DIV_ITER2_EN: two quotient bits per CALC cycle instead of one.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// CALC  | restoring division, quotient bits MSB first
// ROUND | normalize, round, overflow/underflow
// DONE  | out_valid=1 until out_ready
module fp_div_seq #(
  parameter int QBITS = 27
) (
  input logic        clk,
  input logic        rst,
  fp_div_seq_if.slave bus
);
`ifdef FP_DIV_ITER2_EN
  localparam int QW    = QBITS + 1;
  localparam int STEPS = QW / 2;
`else
  localparam int QW    = QBITS;
  localparam int STEPS = QW;
`endif

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t            state;
  logic [QW-1:0]     q_r;
  logic [24:0]       rem_r;
  logic [23:0]       div_r;
  logic signed [9:0] e_r;
  logic              s_r;
  logic [2:0]        mode_r;
  logic [4:0]        cnt;
  logic              in_ready_r, out_valid_r, ovrf_r, udrf_r, dz_r;
  logic [31:0]       z_r;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.fp_Z      = z_r;
  assign bus.ovrf      = ovrf_r;
  assign bus.udrf      = udrf_r;
  assign bus.div_zero  = dz_r;

  // operand classification, subnormals read as zero
  logic [7:0]  ex, ey;
  logic [22:0] fx, fy;
  logic        s_in, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  assign ex     = bus.fp_X[30:23];
  assign ey     = bus.fp_Y[30:23];
  assign fx     = bus.fp_X[22:0];
  assign fy     = bus.fp_Y[22:0];
  assign s_in   = bus.fp_X[31] ^ bus.fp_Y[31];
  assign x_zero = (ex == 8'h00);
  assign y_zero = (ey == 8'h00);
  assign x_inf  = (ex == 8'hFF) && (fx == 23'd0);
  assign y_inf  = (ey == 8'hFF) && (fy == 23'd0);
  assign x_nan  = (ex == 8'hFF) && (fx != 23'd0);
  assign y_nan  = (ey == 8'hFF) && (fy != 23'd0);

  logic        spec, spec_dz;
  logic [31:0] spec_z;
  always_comb begin
    spec    = 1'b1;
    spec_dz = 1'b0;
    spec_z  = 32'd0;
    if (x_nan || y_nan || (x_inf && y_inf) || (x_zero && y_zero))
      spec_z = 32'h7FC0_0000;
    else if (x_inf)
      spec_z = {s_in, 8'hFF, 23'd0};
    else if (y_inf)
      spec_z = {s_in, 31'd0};
    else if (y_zero) begin
      spec_z  = {s_in, 8'hFF, 23'd0};
      spec_dz = 1'b1;
    end else if (x_zero)
      spec_z = {s_in, 31'd0};
    else
      spec = 1'b0;
  end

  // one restoring step: {quotient bit, next remainder already shifted}
  function automatic logic [25:0] div_step(input logic [24:0] r, input logic [23:0] d);
    logic [24:0] diff;
    diff = r - {1'b0, d};
    if (r >= {1'b0, d})
      return {1'b1, diff[23:0], 1'b0};
    else
      return {1'b0, r[23:0], 1'b0};
  endfunction

  logic [25:0] step1;
  assign step1 = div_step(rem_r, div_r);
`ifdef FP_DIV_ITER2_EN
  logic [25:0] step2;
  logic        xtra;
  assign step2 = div_step(step1[24:0], div_r);
  assign xtra  = q_r[0];
`else
  logic        xtra;
  assign xtra  = 1'b0;
`endif

  logic [26:0]       qn;
  logic [22:0]       mant;
  logic [23:0]       mant_r;
  logic              g, st, up, to_inf, rnd_ovf, rnd_udf;
  logic signed [9:0] e_n, e_f;
  logic [31:0]       rnd_z;
  assign qn = q_r[QW-1 -: 27];

  always_comb begin
    if (qn[26]) begin
      mant = qn[25:3];
      g    = qn[2];
      st   = (|qn[1:0]) | (|rem_r) | xtra;
      e_n  = e_r;
    end else begin
      mant = qn[24:2];
      g    = qn[1];
      st   = qn[0] | (|rem_r) | xtra;
      e_n  = e_r - 10'sd1;
    end
    case (mode_r)
      3'b001:  begin up = 1'b0;              to_inf = 1'b0;  end
      3'b010:  begin up = s_r & (g | st);    to_inf = s_r;   end
      3'b011:  begin up = ~s_r & (g | st);   to_inf = ~s_r;  end
      3'b100:  begin up = g;                 to_inf = 1'b1;  end
      default: begin up = g & (st | mant[0]); to_inf = 1'b1; end
    endcase
    mant_r  = {1'b0, mant} + {23'd0, up};
    e_f     = e_n + (mant_r[23] ? 10'sd1 : 10'sd0);
    rnd_ovf = (e_f >= 10'sd255);
    rnd_udf = (e_f <= 10'sd0);
    if (rnd_ovf)
      rnd_z = to_inf ? {s_r, 8'hFF, 23'd0} : {s_r, 31'h7F7F_FFFF};
    else if (rnd_udf)
      rnd_z = {s_r, 31'd0};
    else
      rnd_z = {s_r, e_f[7:0], mant_r[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      z_r         <= 32'd0;
      ovrf_r      <= 1'b0;
      udrf_r      <= 1'b0;
      dz_r        <= 1'b0;
      q_r         <= '0;
      rem_r       <= '0;
      div_r       <= '0;
      e_r         <= '0;
      s_r         <= 1'b0;
      mode_r      <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && in_ready_r) begin
          s_r        <= s_in;
          mode_r     <= bus.r_mode;
          ovrf_r     <= 1'b0;
          udrf_r     <= 1'b0;
          dz_r       <= spec_dz;
          in_ready_r <= 1'b0;
          if (spec) begin
            z_r         <= spec_z;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            rem_r <= {2'b01, fx};
            div_r <= {1'b1, fy};
            e_r   <= $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;
            q_r   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
`ifdef FP_DIV_ITER2_EN
          q_r   <= {q_r[QW-3:0], step1[25], step2[25]};
          rem_r <= step2[24:0];
`else
          q_r   <= {q_r[QW-2:0], step1[25]};
          rem_r <= step1[24:0];
`endif
          cnt <= cnt + 5'd1;
          if (cnt == 5'(STEPS - 1))
            state <= ROUND;
        end
        ROUND: begin
          z_r         <= rnd_z;
          ovrf_r      <= rnd_ovf;
          udrf_r      <= rnd_udf;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
